// File: rtl/lc3_pkg.sv
// Shared LC-3 MMIO constants: device addresses, access FSM states, seven-segment glyphs.
package lc3_pkg;

    localparam logic [15:0] ADDR_KBSR = 16'hFE00;
    localparam logic [15:0] ADDR_KBDR = 16'hFE02;
    localparam logic [15:0] ADDR_DSR  = 16'hFE04;
    localparam logic [15:0] ADDR_DDR  = 16'hFE06;
    localparam logic [15:0] ADDR_MCR  = 16'hFFFE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/lc3_hex7seg.sv
// Hex nibble to active-low seven-segment glyph.
// Latency: combinational. Backpressure: none.
// Pure decode, no state.
module lc3_hex7seg
    import lc3_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_0;
        case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            default: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/lc3_mmio_ctrl.sv
// LC-3 memory controller: RAM plus keyboard, display and machine-control registers.
// Latency: r pulses MEM_LATENCY+1 cycles after the accept cycle; MEM_LATENCY+2 cycles per access.
// Backpressure: requests are only accepted in IDLE; mem_en is ignored until the access completes.
module lc3_mmio_ctrl
    import lc3_pkg::*;
#(
    parameter int MEM_LATENCY = 2,
    parameter int DISP_BUSY   = 4,
    parameter int RAM_AW      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] mar,
    input  logic [15:0] mdr_in,
    input  logic        mem_en,
    input  logic        mem_w,
    output logic [15:0] mem_out,
    output logic        r,
    input  logic [9:0]  switches,
    input  logic [3:0]  key,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [9:0]  ledr,
    output logic        halted
);

    localparam int BW = $clog2(DISP_BUSY + 1);

    state_t         state;
    logic [3:0]     wait_cnt;
    logic [15:0]    lat_mar;
    logic [15:0]    lat_mdr;
    logic           lat_w;

    logic           kbsr15;
    logic [9:0]     kbdr;
    logic           dsr15;
    logic [BW-1:0]  busy_cnt;
    logic [15:0]    ddr;
    logic           mcr15;
    logic           key_s1, key_s2, key_d;
    logic           key_fall;

    logic [15:0]    ram [0:(1<<RAM_AW)-1];
    logic [15:0]    rd_dat;
    logic           is_dev;
    logic           done_wr, done_rd;
    logic           unused_key;

    assign unused_key = ^{key[3:2], key[0]};
    assign key_fall   = key_d & ~key_s2;
    assign done_wr    = (state == ST_DONE) &&  lat_w;
    assign done_rd    = (state == ST_DONE) && !lat_w;
    assign is_dev     = (lat_mar == ADDR_KBSR) || (lat_mar == ADDR_KBDR) || (lat_mar == ADDR_DSR)
                     || (lat_mar == ADDR_DDR)  || (lat_mar == ADDR_MCR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            r        <= 1'b0;
            wait_cnt <= 4'd0;
            lat_mar  <= 16'h0;
            lat_mdr  <= 16'h0;
            lat_w    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    r <= 1'b0;
                    if (mem_en) begin
                        state    <= ST_WAIT;
                        lat_mar  <= mar;
                        lat_mdr  <= mdr_in;
                        lat_w    <= mem_w;
                        wait_cnt <= 4'(MEM_LATENCY - 1);
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= ST_DONE;
                        r     <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    r     <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    r     <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rd_dat = 16'h0;
        case (lat_mar)
            ADDR_KBSR: rd_dat = {kbsr15, 15'b0};
            ADDR_KBDR: rd_dat = {6'b0, kbdr};
            ADDR_DSR:  rd_dat = {dsr15, 15'b0};
            ADDR_DDR:  rd_dat = ddr;
            ADDR_MCR:  rd_dat = {mcr15, 15'b0};
            default:   rd_dat = ram[lat_mar[RAM_AW-1:0]];
        endcase
    end

    assign mem_out = done_rd ? rd_dat : 16'h0;

    // Later assignments win: a key edge overrides the KBDR-read clear, a DDR write overrides the busy countdown.
    always_ff @(posedge clk) begin
        if (reset) begin
            kbsr15   <= 1'b0;
            kbdr     <= 10'h0;
            dsr15    <= 1'b1;
            busy_cnt <= '0;
            ddr      <= 16'h0;
            mcr15    <= 1'b1;
            key_s1   <= 1'b1;
            key_s2   <= 1'b1;
            key_d    <= 1'b1;
        end else begin
            key_s1 <= key[1];
            key_s2 <= key_s1;
            key_d  <= key_s2;
            if (done_rd && lat_mar == ADDR_KBDR) kbsr15 <= 1'b0;
            if (key_fall) begin
                kbsr15 <= 1'b1;
                kbdr   <= switches;
            end
            if (busy_cnt != '0) begin
                busy_cnt <= busy_cnt - 1'b1;
                if (busy_cnt == BW'(1)) dsr15 <= 1'b1;
            end
            if (done_wr && lat_mar == ADDR_DDR) begin
                ddr      <= lat_mdr;
                dsr15    <= 1'b0;
                busy_cnt <= BW'(DISP_BUSY);
            end
            if (done_wr && lat_mar == ADDR_MCR) mcr15 <= lat_mdr[15];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && done_wr && !is_dev) ram[lat_mar[RAM_AW-1:0]] <= lat_mdr;
    end

    lc3_hex7seg u_hex0 (.nib(ddr[3:0]),   .seg(HEX0));
    lc3_hex7seg u_hex1 (.nib(ddr[7:4]),   .seg(HEX1));
    lc3_hex7seg u_hex2 (.nib(ddr[11:8]),  .seg(HEX2));
    lc3_hex7seg u_hex3 (.nib(ddr[15:12]), .seg(HEX3));

    assign ledr   = {kbsr15, dsr15, mcr15, 7'b0};
    assign halted = ~mcr15;

endmodule

// File: tb/tb_lc3_mmio_ctrl.sv
// Testbench for lc3_mmio_ctrl: directed table, hand sequences for timing corners, random ops vs model.
module tb_lc3_mmio_ctrl;
    import lc3_pkg::*;

    localparam int ML = 2;
    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mar, mdr_in, mem_out;
    logic        mem_en, mem_w, r;
    logic [9:0]  switches, ledr;
    logic [3:0]  key;
    logic [6:0]  hex0, hex1, hex2, hex3;
    logic        halted;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int done_cyc = 0;

    lc3_mmio_ctrl #(.MEM_LATENCY(ML), .DISP_BUSY(DB), .RAM_AW(16)) dut (
        .clk(clk), .reset(reset), .mar(mar), .mdr_in(mdr_in), .mem_en(mem_en), .mem_w(mem_w),
        .mem_out(mem_out), .r(r), .switches(switches), .key(key),
        .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3), .ledr(ledr), .halted(halted)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: register values plus the cycle at which DDR was last written.
    logic        m_kbsr;
    logic [9:0]  m_kbdr;
    logic [15:0] m_ddr;
    logic        m_mcr;
    int          m_ddr_wcyc;
    logic [15:0] m_ram [logic [15:0]];

    localparam logic [6:0] G_0 = 7'b1000000;
    localparam logic [6:0] G_B = 7'b0000011;
    localparam logic [6:0] G_E = 7'b0000110;

    function automatic logic m_dsr(input int c);
        return (c - m_ddr_wcyc) >= DB;
    endfunction

    function automatic void m_reset();
        m_kbsr = 1'b0; m_kbdr = 10'h0; m_ddr = 16'h0; m_mcr = 1'b1; m_ddr_wcyc = -1000;
    endfunction

    function automatic void m_write(input logic [15:0] a, input logic [15:0] d, input int dc);
        case (a)
            ADDR_KBSR, ADDR_KBDR, ADDR_DSR: ;
            ADDR_DDR: begin m_ddr = d; m_ddr_wcyc = dc + 1; end
            ADDR_MCR: m_mcr = d[15];
            default:  m_ram[a] = d;
        endcase
    endfunction

    function automatic logic [15:0] m_read(input logic [15:0] a, input int dc);
        logic [15:0] v;
        case (a)
            ADDR_KBSR: v = {m_kbsr, 15'b0};
            ADDR_KBDR: begin v = {6'b0, m_kbdr}; m_kbsr = 1'b0; end
            ADDR_DSR:  v = {m_dsr(dc), 15'b0};
            ADDR_DDR:  v = m_ddr;
            ADDR_MCR:  v = {m_mcr, 15'b0};
            default:   v = m_ram.exists(a) ? m_ram[a] : 16'h0;
        endcase
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Caller is positioned just after a falling edge with the controller idle.
    task automatic access(input logic [15:0] a, input logic [15:0] d, input logic w,
                          input string nm, output logic [15:0] rd);
        int lat;
        lat = -1;
        rd  = 16'h0;
        mar = a; mdr_in = d; mem_w = w; mem_en = 1'b1;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                mem_en = 1'b0; mar = 16'($urandom); mdr_in = 16'($urandom); mem_w = 1'($urandom);
            end
            if (r) begin lat = k; rd = mem_out; done_cyc = cyc; end
        end
        check({nm, "/lat"}, lat, ML + 1);
        if (lat > 0) begin
            @(negedge clk);
            check({nm, "/idle"}, {15'b0, r, mem_out}, 32'h0);
        end
    endtask

    task automatic op(input logic [15:0] a, input logic [15:0] d, input logic w, input string nm);
        logic [15:0] rd, exp;
        access(a, d, w, nm, rd);
        if (w) m_write(a, d, done_cyc);
        else begin
            exp = m_read(a, done_cyc);
            check(nm, rd, exp);
        end
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic        w;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [20];
    logic [15:0] pool [8];

    initial begin
        logic [15:0] rd;
        int          r1, r2, nr;
        bit          saw_r;

        vecs[0]  = '{16'h3000, 16'h1234, 1'b1, 16'h0000};
        vecs[1]  = '{16'h3000, 16'h0000, 1'b0, 16'h1234};
        vecs[2]  = '{ADDR_MCR,  16'h0000, 1'b0, 16'h8000};
        vecs[3]  = '{ADDR_KBSR, 16'h0000, 1'b0, 16'h0000};
        vecs[4]  = '{ADDR_KBDR, 16'h0000, 1'b0, 16'h0000};
        vecs[5]  = '{ADDR_DSR,  16'h0000, 1'b0, 16'h8000};
        vecs[6]  = '{ADDR_DDR,  16'h0000, 1'b0, 16'h0000};
        vecs[7]  = '{ADDR_KBSR, 16'hFFFF, 1'b1, 16'h0000};
        vecs[8]  = '{ADDR_KBSR, 16'h0000, 1'b0, 16'h0000};
        vecs[9]  = '{ADDR_KBDR, 16'h1111, 1'b1, 16'h0000};
        vecs[10] = '{ADDR_KBDR, 16'h0000, 1'b0, 16'h0000};
        vecs[11] = '{ADDR_DSR,  16'h0000, 1'b1, 16'h0000};
        vecs[12] = '{ADDR_DSR,  16'h0000, 1'b0, 16'h8000};
        vecs[13] = '{16'h4000, 16'hAAAA, 1'b1, 16'h0000};
        vecs[14] = '{16'h4000, 16'h0000, 1'b0, 16'hAAAA};
        vecs[15] = '{16'hFFFF, 16'h5A5A, 1'b1, 16'h0000};
        vecs[16] = '{16'hFFFF, 16'h0000, 1'b0, 16'h5A5A};
        vecs[17] = '{ADDR_MCR,  16'h0000, 1'b0, 16'h8000};
        vecs[18] = '{16'hFE01, 16'h0BAD, 1'b1, 16'h0000};
        vecs[19] = '{16'hFE01, 16'h0000, 1'b0, 16'h0BAD};

        reset = 1'b1; mar = 16'h0; mdr_in = 16'h0; mem_en = 1'b0; mem_w = 1'b0;
        switches = 10'h0; key = 4'hF;
        m_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst/r_mem_out", {15'b0, r, mem_out}, 32'h0);
        check("rst/ledr", ledr, 10'b0110000000);
        check("rst/halted", halted, 1'b0);
        check("rst/hex", {hex3, hex2, hex1, hex0}, {G_0, G_0, G_0, G_0});

        for (int i = 0; i < 20; i++) begin
            access(vecs[i].addr, vecs[i].data, vecs[i].w, $sformatf("vec%0d", i), rd);
            if (vecs[i].w) m_write(vecs[i].addr, vecs[i].data, done_cyc);
            else check($sformatf("vec%0d/rd", i), rd, vecs[i].exp);
        end

        // Back-to-back reads with mem_en held high.
        mar = 16'h3000; mem_w = 1'b0; mem_en = 1'b1;
        r1 = -1; r2 = -1; nr = 0;
        for (int k = 1; k <= 30 && r2 < 0; k++) begin
            @(negedge clk);
            if (r) begin
                if (r1 < 0) begin r1 = k; check("b2b/rd", mem_out, 16'h1234); end
                else begin r2 = k; mem_en = 1'b0; end
            end
        end
        check("b2b/first", r1, ML + 1);
        check("b2b/spacing", r2 - r1, ML + 2);
        @(negedge clk);

        // Keyboard press.
        switches = 10'h2A5;
        key[1] = 1'b0;
        repeat (4) @(negedge clk);
        key[1] = 1'b1;
        repeat (4) @(negedge clk);
        m_kbsr = 1'b1; m_kbdr = 10'h2A5;
        check("kbd/ledr9", ledr[9], 1'b1);
        op(ADDR_KBSR, 16'h0, 1'b0, "kbd/kbsr1");
        op(ADDR_KBDR, 16'h0, 1'b0, "kbd/kbdr");
        op(ADDR_KBSR, 16'h0, 1'b0, "kbd/kbsr2");

        // Key edge lands in the DONE cycle of a KBDR read.
        mar = ADDR_KBDR; mem_w = 1'b0; mem_en = 1'b1;
        r1 = -1;
        for (int k = 1; k <= 20 && r1 < 0; k++) begin
            @(negedge clk);
            if (k == 1) begin mem_en = 1'b0; key[1] = 1'b0; switches = 10'h155; end
            if (r) begin r1 = k; rd = mem_out; end
        end
        check("sim/lat", r1, ML + 1);
        check("sim/old_kbdr", rd, 16'h02A5);
        @(negedge clk);
        m_kbsr = 1'b1; m_kbdr = 10'h155;
        check("sim/kbsr_set", ledr[9], 1'b1);
        key[1] = 1'b1;
        repeat (3) @(negedge clk);
        op(ADDR_KBSR, 16'h0, 1'b0, "sim/kbsr");
        op(ADDR_KBDR, 16'h0, 1'b0, "sim/kbdr_new");

        // Display busy window.
        op(ADDR_DDR, 16'h00BE, 1'b1, "disp/wr");
        check("disp/hex", {hex3, hex2, hex1, hex0}, {G_0, G_0, G_B, G_E});
        check("disp/ledr8_busy", ledr[8], 1'b0);
        op(ADDR_DSR, 16'h0, 1'b0, "disp/dsr_busy");
        op(ADDR_DSR, 16'h0, 1'b0, "disp/dsr_ready");
        op(ADDR_DDR, 16'h0, 1'b0, "disp/ddr_rd");
        op(ADDR_DDR, 16'h1111, 1'b1, "disp/wr2");
        op(ADDR_DDR, 16'h2222, 1'b1, "disp/wr_restart");
        for (int i = 0; i < 7; i++) begin
            check($sformatf("disp/ledr8_c%0d", i), ledr[8], m_dsr(cyc));
            @(negedge clk);
        end

        // Halt.
        op(ADDR_MCR, 16'h0000, 1'b1, "halt/wr");
        check("halt/halted", halted, 1'b1);
        op(ADDR_MCR, 16'h0, 1'b0, "halt/mcr_rd");
        op(ADDR_MCR, 16'h8000, 1'b1, "halt/resume");
        check("halt/running", {halted, ledr[7]}, 2'b01);

        // Reset during WAIT of a write to x4000.
        mar = 16'h4000; mdr_in = 16'hFFFF; mem_w = 1'b1; mem_en = 1'b1;
        @(negedge clk);
        mem_en = 1'b0; reset = 1'b1;
        saw_r = 1'b0;
        for (int i = 0; i < 3; i++) begin @(negedge clk); if (r) saw_r = 1'b1; end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin @(negedge clk); if (r) saw_r = 1'b1; end
        check("rstmid/no_r", saw_r, 1'b0);
        m_reset();
        check("rstmid/ledr", ledr, 10'b0110000000);
        op(16'h4000, 16'h0, 1'b0, "rstmid/ram_kept");

        // Random operations against the model.
        for (int i = 0; i < 8; i++) begin
            pool[i] = 16'h5000 + 16'(i * 37);
            op(pool[i], 16'($urandom), 1'b1, "rnd/init");
        end
        for (int i = 0; i < 60; i++) begin
            int sel;
            logic [15:0] a;
            sel = $urandom_range(0, 9);
            a = pool[$urandom_range(0, 7)];
            case (sel)
                0, 1: op(a, 16'($urandom), 1'b1, "rnd/ram_wr");
                2, 3: op(a, 16'h0, 1'b0, "rnd/ram_rd");
                4:    op(ADDR_DDR, 16'($urandom), 1'b1, "rnd/ddr_wr");
                5:    op(ADDR_DDR, 16'h0, 1'b0, "rnd/ddr_rd");
                6:    op(ADDR_DSR, 16'h0, 1'b0, "rnd/dsr_rd");
                7:    op(ADDR_MCR, 16'($urandom), 1'b1, "rnd/mcr_wr");
                8:    op(ADDR_MCR, 16'h0, 1'b0, "rnd/mcr_rd");
                default: op(ADDR_KBDR, 16'h0, 1'b0, "rnd/kbdr_rd");
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
